// File: rtl/lossy_stream_if.sv
// lossy_stream_if: valid-only source side and ready/valid sink side of the lossy buffer
interface lossy_stream_if #(
  parameter type T = logic [31:0]
) ();
  logic valid_i;
  T     data_i;
  logic valid_o;
  logic ready_i;
  T     data_o;
  modport slave (input valid_i, data_i, ready_i, output valid_o, data_o);
  modport master (output valid_i, data_i, ready_i, input valid_o, data_o);
endinterface

// File: rtl/lossy_stream_fifo.sv
// lossy_stream_fifo: lossy valid-to-stream circular buffer with overflow policy, fall-through and drop counter
module lossy_stream_fifo #(
  parameter int  DATA_WIDTH   = 32,
  parameter type T            = logic [DATA_WIDTH-1:0],
  parameter int  DEPTH        = 2,
  parameter int  MODE         = 0,
  parameter bit  FALL_THROUGH = 1,
  parameter int  CNT_WIDTH    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  lossy_stream_if.slave              bus,
  input  logic                       flush_i,
  input  logic                       clr_drop_i,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] usage_o,
  output logic                       drop_o,
  output logic [CNT_WIDTH-1:0]       drop_cnt_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  T mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt, wr_prev;
  logic [CW-1:0] cnt;
  logic empty, full, bypass, pop, pop_mem, push, overwrite;
  assign empty = cnt == '0;
  assign full = cnt == CW'(DEPTH);
  assign bypass = FALL_THROUGH && empty && bus.valid_i;
  assign bus.valid_o = !empty || bypass;
  assign bus.data_o = empty ? bus.data_i : mem[rd_ptr];
  assign pop = bus.valid_o && bus.ready_i;
  assign pop_mem = pop && !empty;
  assign push = bus.valid_i && !flush_i && !(bypass && bus.ready_i) && (!full || pop);
  assign drop_o = rst_ni && bus.valid_i && !flush_i && full && !pop;
  assign overwrite = drop_o && MODE == 0;
  assign rd_nxt = rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + PW'(1);
  assign wr_nxt = wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1);
  assign wr_prev = wr_ptr == '0 ? PW'(DEPTH - 1) : wr_ptr - PW'(1);
  assign busy_o = !empty;
  assign usage_o = cnt;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      if (pop_mem) rd_ptr <= rd_nxt;
      if (push) wr_ptr <= wr_nxt;
      cnt <= cnt + CW'(push) - CW'(pop_mem);
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) mem <= '{default: '0};
    else if (push) mem[wr_ptr] <= bus.data_i;
    else if (overwrite) mem[wr_prev] <= bus.data_i;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) drop_cnt_o <= '0;
    else if (clr_drop_i) drop_cnt_o <= CNT_WIDTH'(drop_o);
    else if (drop_o && !(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + CNT_WIDTH'(1);
  end
endmodule

// File: tb/tb_lossy_stream_fifo.sv
// tb_lossy_stream_fifo: four configurations driven in lockstep, checked against a queue model every cycle
module tb_lossy_stream_fifo;
  localparam int NI = 4;
  function automatic int p_dep(int i);
    return i < 2 ? 4 : i == 2 ? 3 : 5;
  endfunction
  function automatic int p_mode(int i);
    return i % 2;
  endfunction
  function automatic int p_ft(int i);
    return i >= 2 ? 1 : 0;
  endfunction
  function automatic int p_cw(int i);
    return i >= 2 ? 2 : 16;
  endfunction
  logic clk = 0, rst_n = 0, valid = 0, ready = 0, flush = 0, clr = 0;
  logic [31:0] data = 0;
  logic vo [NI], busy [NI], drop [NI];
  logic [31:0] dout [NI];
  logic [7:0] usage [NI];
  logic [15:0] dcnt [NI];
  logic [31:0] q [NI][$];
  int dc_m [NI];
  int checks = 0, fails = 0;
  logic [31:0] e0 [4] = '{32'h1, 32'h2, 32'h3, 32'h6};
  logic [31:0] e1 [4] = '{32'h1, 32'h2, 32'h3, 32'h4};
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D = p_dep(g);
    localparam int CW = p_cw(g);
    logic [$clog2(D+1)-1:0] us;
    logic [CW-1:0] dc;
    lossy_stream_if #(.T(logic [31:0])) bus ();
    assign bus.valid_i = valid;
    assign bus.data_i = data;
    assign bus.ready_i = ready;
    assign vo[g] = bus.valid_o;
    assign dout[g] = bus.data_o;
    assign usage[g] = 8'(us);
    assign dcnt[g] = 16'(dc);
    lossy_stream_fifo #(
      .DATA_WIDTH(32), .DEPTH(D), .MODE(p_mode(g)), .FALL_THROUGH(p_ft(g) != 0), .CNT_WIDTH(CW)
    ) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus), .flush_i(flush), .clr_drop_i(clr),
      .busy_o(busy[g]), .usage_o(us), .drop_o(drop[g]), .drop_cnt_o(dc)
    );
  end
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask
  function automatic void exp_comb(input int i, output logic ve, output logic [31:0] de,
                                   output logic pe, output logic dr);
    int n = q[i].size();
    logic byp = p_ft(i) != 0 && n == 0 && valid;
    ve = n != 0 || byp;
    de = n != 0 ? q[i][0] : data;
    pe = ve && ready;
    dr = rst_n && !flush && valid && n == p_dep(i) && !pe;
  endfunction
  always @(negedge clk) begin
    logic ve, pe, dr;
    logic [31:0] de;
    for (int i = 0; i < NI; i++) begin
      exp_comb(i, ve, de, pe, dr);
      chk("valid_o", i, 32'(vo[i]), 32'(ve));
      if (ve) chk("data_o", i, dout[i], de);
      chk("drop_o", i, 32'(drop[i]), 32'(dr));
      chk("busy_o", i, 32'(busy[i]), 32'(q[i].size() != 0));
      chk("usage_o", i, 32'(usage[i]), 32'(q[i].size()));
      chk("drop_cnt_o", i, 32'(dcnt[i]), 32'(dc_m[i]));
    end
  end
  always @(posedge clk) begin
    logic ve, pe, dr;
    logic [31:0] de;
    int n;
    for (int i = 0; i < NI; i++) begin
      exp_comb(i, ve, de, pe, dr);
      n = q[i].size();
      if (!rst_n) begin
        q[i].delete();
        dc_m[i] = 0;
      end else begin
        if (pe && n != 0) void'(q[i].pop_front());
        if (flush) q[i].delete();
        else if (valid && !(n == 0 && pe)) begin
          if (n < p_dep(i) || pe) q[i].push_back(data);
          else if (p_mode(i) == 0) q[i][q[i].size()-1] = data;
        end
        if (clr) dc_m[i] = dr ? 1 : 0;
        else if (dr && dc_m[i] < (1 << p_cw(i)) - 1) dc_m[i]++;
      end
    end
  end
  task automatic cyc(input logic r_n, input logic v, input logic [31:0] d,
                     input logic rd, input logic f, input logic c);
    @(posedge clk);
    #1;
    rst_n = r_n;
    valid = v;
    data = d;
    ready = rd;
    flush = f;
    clr = c;
    @(negedge clk);
    #1;
  endtask
  initial begin
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NI; i++) begin
      chk("rst_usage", i, 32'(usage[i]), 0);
      chk("rst_busy", i, 32'(busy[i]), 0);
      chk("rst_dcnt", i, 32'(dcnt[i]), 0);
      chk("rst_valid", i, 32'(vo[i]), 0);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc(1, 1, 32'(k), 0, 0, 0);
      if (k >= 5) chk("ovf_drop", 0, 32'(drop[0]), 1);
    end
    for (int j = 0; j < 4; j++) begin
      cyc(1, 0, 0, 1, 0, 0);
      if (j == 0) begin
        chk("fill_usage", 0, 32'(usage[0]), 4);
        chk("latest_dcnt", 0, 32'(dcnt[0]), 2);
        chk("oldest_dcnt", 1, 32'(dcnt[1]), 2);
        chk("sat_dcnt", 2, 32'(dcnt[2]), 3);
      end
      chk("latest_data", 0, dout[0], e0[j]);
      chk("oldest_data", 1, dout[1], e1[j]);
    end
    cyc(1, 0, 0, 1, 0, 0);
    chk("drain_usage", 0, 32'(usage[0]), 0);
    cyc(1, 1, 32'hA, 1, 0, 0);
    chk("ft_valid", 2, 32'(vo[2]), 1);
    chk("ft_data", 2, dout[2], 32'hA);
    cyc(1, 0, 0, 1, 0, 0);
    chk("ft_busy", 2, 32'(busy[2]), 0);
    cyc(1, 1, 32'hA, 0, 0, 0);
    chk("ft_stall_valid", 2, 32'(vo[2]), 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("ft_hold_data", 2, dout[2], 32'hA);
    chk("ft_hold_usage", 2, 32'(usage[2]), 1);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 1, 32'h11, 0, 0, 0);
    cyc(1, 1, 32'h22, 0, 0, 0);
    cyc(1, 1, 32'h33, 1, 1, 0);
    chk("flush_data", 0, dout[0], 32'h11);
    cyc(1, 0, 0, 0, 0, 0);
    chk("flush_usage", 0, 32'(usage[0]), 0);
    chk("flush_dcnt", 0, 32'(dcnt[0]), 2);
    for (int k = 1; k <= 3; k++) cyc(1, 1, 32'(k), 0, 0, 0);
    cyc(1, 1, 32'h4, 0, 0, 1);
    chk("clr_drop", 2, 32'(drop[2]), 1);
    cyc(1, 0, 0, 1, 0, 0);
    chk("clr_with_drop", 2, 32'(dcnt[2]), 1);
    chk("clr_no_drop", 0, 32'(dcnt[0]), 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("midrst_usage", 0, 32'(usage[0]), 0);
    chk("midrst_busy", 0, 32'(busy[0]), 0);
    chk("midrst_valid", 0, 32'(vo[0]), 0);
    chk("midrst_dcnt", 2, 32'(dcnt[2]), 0);
    for (int k = 1; k <= 8; k++) cyc(1, 1, 32'(k), 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("sat5_dcnt", 2, 32'(dcnt[2]), 3);
    chk("dcnt4", 0, 32'(dcnt[0]), 4);
    for (int k = 0; k < 8; k++) begin
      cyc(1, 1, 32'h40 + 32'(k), 1, 0, 0);
      chk("full_pp_usage", 2, 32'(usage[2]), 3);
      chk("full_pp_drop", 2, 32'(drop[2]), 0);
    end
    for (int k = 0; k < 4000; k++) begin
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, $urandom,
          k % 1000 < 500 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 49) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
